// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter serial front end: controller state
// encoding and the word length shared with the deserializer.
package fir_pkg;

   // Default data bits per word; the deserializer uses the same constant
   localparam int LENGTH_DEF  = 24;
   // Default i_clk cycles without a bit clock edge before a word is dropped
   localparam int TIMEOUT_DEF = 256;

   // Controller states: HUNT = 2'd0, SHIFT = 2'd1, LATCH = 2'd2
   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

endpackage

// File: rtl/deserializer_ctrl_if.sv
// Strobe bus from the deserializer controller to the deserializer:
// per-bit shift enable, the bit itself, and the word-latch strobe.
interface deserializer_ctrl_if;

   logic des_en;
   logic des_din;
   logic des_din_valid;

   modport master (output des_en, output des_din, output des_din_valid);
   modport slave  (input  des_en, input  des_din, input  des_din_valid);

endinterface

// File: rtl/deserializer_ctrl_sync_edge_detect.sv
// Single-bit 2-FF synchroniser with a one-cycle rising-edge pulse taken
// from the synchronised output and a one-cycle delayed copy of it.
module sync_edge_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Two synchroniser stages followed by the delay stage used for edge detection
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= i_async;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign o_sync = sync_q;
   assign o_rise = sync_q & ~prev_q;

endmodule

// File: rtl/deserializer_ctrl.sv
// Deserializer front-end sequencer: samples the LSB-first serial link,
// aligns on frame sync, issues per-bit shift strobes and one latch strobe
// per complete word, and drops partial words on resync, timeout or disable.
module deserializer_ctrl
   import fir_pkg::*;
#(
   parameter int LENGTH  = LENGTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_en,
   input  logic                         i_sclk,
   input  logic                         i_fsync,
   input  logic                         i_sdata,
   deserializer_ctrl_if.master          des_if,
   output logic                         o_busy,
   output logic                         o_frame_err,
   output logic [$clog2(LENGTH+1)-1:0]  ov_bit_cnt
);

   localparam int CW = $clog2(LENGTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LEN_C   = CW'(LENGTH);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

   // Lane 0 = sclk, lane 1 = fsync, lane 2 = sdata; all share one pipeline
   // depth so fsync/sdata are aligned with the detected sclk rise.
   logic [2:0] async_vec;
   logic [2:0] sync_vec;
   logic [2:0] rise_vec;

   assign async_vec = {i_sdata, i_fsync, i_sclk};

   for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync_edge_detect u_sync (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_async (async_vec[gi]),
         .o_sync  (sync_vec[gi]),
         .o_rise  (rise_vec[gi])
      );
   end

   logic sclk_rise;
   logic fsync_s;
   logic sdata_s;
   logic unused_lanes;

   assign sclk_rise    = rise_vec[0];
   assign fsync_s      = sync_vec[1];
   assign sdata_s      = sync_vec[2];
   // Synchronised sclk level and fsync/sdata edges are not needed
   assign unused_lanes = ^{sync_vec[0], rise_vec[2:1]};

   state_t          state_q;
   logic [CW-1:0]   bit_cnt_q;
   logic [TW-1:0]   to_cnt_q;
   logic            pend_q;
   logic            pend_fsync_q;
   logic            pend_sdata_q;
   logic            des_en_q;
   logic            des_din_q;
   logic            des_valid_q;
   logic            frame_err_q;

   // Saturating increments for the bit and timeout counters
   logic [CW-1:0]   bit_cnt_inc_d;
   logic [TW-1:0]   to_cnt_inc_d;

   assign bit_cnt_inc_d = (bit_cnt_q == LEN_C)  ? bit_cnt_q : bit_cnt_q + CW'(1);
   assign to_cnt_inc_d  = (to_cnt_q  == TO_MAX) ? to_cnt_q  : to_cnt_q  + TW'(1);

   // In HUNT a rise captured during LATCH is replayed from the pending flag
   logic hunt_rise;
   logic hunt_fsync;
   logic hunt_sdata;

   assign hunt_rise  = pend_q | sclk_rise;
   assign hunt_fsync = pend_q ? pend_fsync_q : fsync_s;
   assign hunt_sdata = pend_q ? pend_sdata_q : sdata_s;

   // Controller FSM with registered strobes, counters and pending flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= HUNT;
         bit_cnt_q    <= '0;
         to_cnt_q     <= '0;
         pend_q       <= 1'b0;
         pend_fsync_q <= 1'b0;
         pend_sdata_q <= 1'b0;
         des_en_q     <= 1'b0;
         des_din_q    <= 1'b0;
         des_valid_q  <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         des_en_q    <= 1'b0;
         des_din_q   <= 1'b0;
         des_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         if (!i_en) begin
            // Quiet abandon: no error pulse, synchronisers keep running
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            pend_q       <= 1'b0;
            pend_fsync_q <= 1'b0;
            pend_sdata_q <= 1'b0;
         end else begin
            case (state_q)
               HUNT: begin
                  pend_q   <= 1'b0;
                  to_cnt_q <= '0;
                  if (hunt_rise && hunt_fsync) begin
                     des_en_q  <= 1'b1;
                     des_din_q <= hunt_sdata;
                     bit_cnt_q <= CW'(1);
                     state_q   <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (bit_cnt_q == LEN_C) begin
                     state_q <= LATCH;
                  end else if (sclk_rise) begin
                     to_cnt_q  <= '0;
                     des_en_q  <= 1'b1;
                     des_din_q <= sdata_s;
                     if (fsync_s) begin
                        // Misplaced frame sync: restart the word on this bit
                        frame_err_q <= 1'b1;
                        bit_cnt_q   <= CW'(1);
                     end else begin
                        bit_cnt_q <= bit_cnt_inc_d;
                     end
                  end else if (to_cnt_q >= TO_LAST) begin
                     // Bit clock lost: discard the partial word
                     frame_err_q <= 1'b1;
                     state_q     <= HUNT;
                     bit_cnt_q   <= '0;
                     to_cnt_q    <= '0;
                  end else begin
                     to_cnt_q <= to_cnt_inc_d;
                  end
               end
               LATCH: begin
                  // Deserializer latches its pre-shift contents; the dummy 0
                  // shifted in here is flushed by the next word.
                  des_en_q    <= 1'b1;
                  des_valid_q <= 1'b1;
                  des_din_q   <= 1'b0;
                  bit_cnt_q   <= '0;
                  to_cnt_q    <= '0;
                  state_q     <= HUNT;
                  if (sclk_rise) begin
                     pend_q       <= 1'b1;
                     pend_fsync_q <= fsync_s;
                     pend_sdata_q <= sdata_s;
                  end
               end
               default: begin
                  state_q   <= HUNT;
                  bit_cnt_q <= '0;
                  to_cnt_q  <= '0;
               end
            endcase
         end
      end
   end

   assign des_if.des_en        = des_en_q;
   assign des_if.des_din       = des_din_q;
   assign des_if.des_din_valid = des_valid_q;
   assign o_busy               = (state_q == SHIFT) || (state_q == LATCH);
   assign o_frame_err          = frame_err_q;
   assign ov_bit_cnt           = bit_cnt_q;

endmodule

// File: doc/deserializer_ctrl.md
Name: deserializer_ctrl

Overview:
Front-end sequencer for the FIR filter's serial input deserializer. Samples an external LSB-first serial link (bit clock, frame sync, data) in the i_clk domain and issues per-bit shift strobes plus one word-latch strobe per frame. Handles frame alignment, resync on misplaced frame sync, and bit-clock loss, so the deserializer only ever presents complete, aligned LENGTH-bit words.

Parameters:
LENGTH, 24, data bits per word; must match the deserializer LENGTH
TIMEOUT, 256, i_clk cycles without an i_sclk rising edge before an in-progress word is abandoned

Ports:
i_clk  input  1  system clock, single clock domain
i_rst_n  input  1  asynchronous, active-low reset
i_en  input  1  controller enable; low holds the FSM in HUNT
i_sclk  input  1  external serial bit clock, asynchronous to i_clk
i_fsync  input  1  frame sync, high on the sclk edge carrying bit 0
i_sdata  input  1  serial data, LSB first
o_des_en  output  1  one-cycle shift strobe to the deserializer i_en
o_des_din  output  1  bit to the deserializer i_din
o_des_din_valid  output  1  word-latch strobe to the deserializer i_din_valid
o_busy  output  1  high in SHIFT or LATCH
o_frame_err  output  1  one-cycle pulse on resync or timeout
ov_bit_cnt  output  $clog2(LENGTH+1)  bits shifted into the current word

Behaviour:
- Reset (async, i_rst_n=0): state=HUNT; all outputs 0; sync/edge registers, bit counter, timeout counter and pending flag cleared.
- Input capture: i_sclk, i_fsync and i_sdata each pass through a 2-FF synchroniser plus one delay register for sclk. A rise is detected when sclk_sync=1 and sclk_prev=0. Latency is 3 i_clk cycles from the i_sclk edge to the strobe. fsync and sdata are sampled from the same pipeline stage, so they stay aligned with the rise.
- Constraint: the i_sclk period must be at least 8 i_clk cycles. Faster clocks are not supported.
- HUNT: rises with fsync=0 are ignored. On a rise with fsync=1: o_des_en=1, o_des_din=sdata, bit_cnt=1, go to SHIFT.
- SHIFT, on each rise:
  - If fsync=1 and bit_cnt<LENGTH: pulse o_frame_err, treat the bit as a new bit 0 (shift it, bit_cnt=1), stay in SHIFT.
  - Otherwise shift the bit and increment bit_cnt.
  - The cycle after bit_cnt reaches LENGTH, go to LATCH.
- LATCH (exactly 1 cycle): o_des_en=1, o_des_din_valid=1, o_des_din=0.
  - The deserializer outputs its pre-shift register, i.e. the LENGTH received bits. The dummy 0 it shifts in is flushed by the next word.
  - Clear bit_cnt and go to HUNT.
- Rise coinciding with LATCH: set a pending flag holding fsync/sdata. The flag is consumed in the next cycle in HUNT, so no bit is lost.
- Timeout: in SHIFT, count i_clk cycles since the last rise. On reaching TIMEOUT: pulse o_frame_err, go to HUNT, clear bit_cnt, and do not assert o_des_din_valid (the partial word is discarded).
- Deasserting i_en mid-word: synchronous abandon. State goes to HUNT, counters clear, strobes stop the same cycle, no o_frame_err. Synchronisers keep running.
- Outputs are registered. o_des_en, o_des_din_valid and o_frame_err are single-cycle pulses.
- Counters saturate and never wrap.
- o_busy=1 in SHIFT and LATCH.

Decomposition:
- Shared package (fir_pkg): state encoding localparams HUNT=2'd0, SHIFT=2'd1, LATCH=2'd2; default LENGTH constant shared with the deserializer.
- Sub-module sync_edge_detect (2-FF synchroniser plus rising-edge pulse, 1-bit). Instantiate it for sclk; fsync and sdata use its plain sync path.
- The top level holds the FSM, bit counter, timeout counter and pending flag.

Test Plan:
- Single word: LENGTH=24, sclk = i_clk/10, send 0xA5F00F LSB-first with fsync on bit 0 -> 24 o_des_en pulses, then 1 LATCH pulse; deserializer ov_dout=0xA5F00F, o_dout_valid=1.
- Back-to-back: words 0x123456 then 0xFEDCBA, fsync on each bit 0 -> two valids with the correct words, no o_frame_err, no lost bit across LATCH.
- Misplaced fsync: fsync asserted on bit 10 of a word, followed by 0x00FF00 -> one o_frame_err pulse; the next valid is 0x00FF00.
- sclk loss: stop sclk after bit 5, wait TIMEOUT+5 cycles -> one o_frame_err pulse, state HUNT, no o_des_din_valid.
- Reset: assert i_rst_n=0 mid-word at bit 12 -> all outputs 0 immediately; after release a full word 0x0F0F0F decodes correctly.
- Enable gating: drop i_en at bit 8, re-raise, send 0x800001 -> no error pulse, no valid for the abandoned word; 0x800001 received.
